// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-register slice.
//   ex_mem_t      : packed Execute->Memory payload at the default widths
//   RESULT_SRC_*  : writeback mux select encodings carried in ResultSrc
//   buf_state_t   : occupancy state of pipe_skid_buf
//   ex_mem_width  : flattened payload width for arbitrary field widths
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    // Writeback mux select encodings
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // Field order here is the packing order used by ex_mem_pipe_reg.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]     alu_result;
        logic [DEF_DATA_WIDTH-1:0]     write_data;
        logic [DEF_REG_ADDR_WIDTH-1:0] rd;
        logic                          reg_write;
        logic [DEF_DATA_WIDTH-1:0]     pc_plus4;
        logic                          mem_write;
        logic                          mem_read;
        logic [1:0]                    result_src;
        logic [2:0]                    funct3;
    } ex_mem_t;

    // Encoding chosen so that bit 0 is "main entry valid" and bit 1 is
    // "skid entry valid"; both are plain flop outputs.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_FULL  = 2'b01,
        BUF_SKID  = 2'b11
    } buf_state_t;

    // Three data-width fields, the register index, and 8 bits of controls
    // (RegWrite, MemWrite, MemRead, ResultSrc[1:0], funct3[2:0]).
    function automatic int ex_mem_width(input int data_w, input int reg_w);
        return 3 * data_w + reg_w + 8;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg_if
// Bundles the Execute-side and Memory-side signals of the EX/MEM register.
//   modport slave  : the pipeline register itself (consumes *E, ReadyM;
//                    produces ReadyE, ValidM and the *M payload)
//   modport master : the surrounding core (Execute + Memory stages)
// -----------------------------------------------------------------------------
interface ex_mem_pipe_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Execute side
    logic                      ValidE;
    logic                      ReadyE;
    logic                      FlushE;
    logic [DATA_WIDTH-1:0]     ALUResultE;
    logic [DATA_WIDTH-1:0]     WriteDataE;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic                      RegWriteE;
    logic [DATA_WIDTH-1:0]     PCPlus4E;
    logic                      MemWriteE;
    logic                      MemReadE;
    logic [1:0]                ResultSrcE;
    logic [2:0]                funct3E;

    // Memory side
    logic                      ValidM;
    logic                      ReadyM;
    logic [DATA_WIDTH-1:0]     ALUResultM;
    logic [DATA_WIDTH-1:0]     WriteDataM;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic                      RegWriteM;
    logic [DATA_WIDTH-1:0]     PCPlus4M;
    logic                      MemWriteM;
    logic                      MemReadM;
    logic [1:0]                ResultSrcM;
    logic [2:0]                funct3M;

    modport slave (
        input  ValidE, FlushE, ALUResultE, WriteDataE, RdE, RegWriteE,
               PCPlus4E, MemWriteE, MemReadE, ResultSrcE, funct3E,
        output ReadyE,
        output ValidM, ALUResultM, WriteDataM, RdM, RegWriteM, PCPlus4M,
               MemWriteM, MemReadM, ResultSrcM, funct3M,
        input  ReadyM
    );

    modport master (
        output ValidE, FlushE, ALUResultE, WriteDataE, RdE, RegWriteE,
               PCPlus4E, MemWriteE, MemReadE, ResultSrcE, funct3E,
        input  ReadyE,
        input  ValidM, ALUResultM, WriteDataM, RdM, RegWriteM, PCPlus4M,
               MemWriteM, MemReadM, ResultSrcM, funct3M,
        output ReadyM
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic valid/ready pipeline buffer over an opaque payload.
//   SKID_EN=1 : two entries (main + skid); in_ready is a flop output so no
//               combinational path runs from out_ready to in_ready.
//   SKID_EN=0 : one entry; in_ready = out_ready | ~out_valid.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   flush                 drop the incoming payload and every stored entry
//   out_valid/out_ready   downstream handshake, out_data = main entry
// The main entry always drives out_data; the payload registers only load on
// an actual transfer so held outputs are bit-stable during a stall.
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter bit SKID_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    buf_state_t           state_reg;
    buf_state_t           state_next;
    logic [PAYLOAD_W-1:0] main_data_reg;
    logic [PAYLOAD_W-1:0] main_data_next;
    logic [PAYLOAD_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    assign out_valid = state_reg[0];
    assign out_data  = main_data_reg;

    // A flushed cycle never stores its input, even when the handshake fires.
    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            logic [PAYLOAD_W-1:0] skid_data_reg;

            // Ready is just the inverted skid-valid flop.
            assign in_ready = ~state_reg[1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_data_reg <= '0;
                end else if (skid_load) begin
                    skid_data_reg <= in_data;
                end
            end

            assign skid_data = skid_data_reg;
        end else begin : g_noskid
            // Single entry: accept whenever it is empty or draining now.
            assign in_ready  = out_ready | ~state_reg[0];
            assign skid_data = '0;
        end
    endgenerate

    // Next-state and datapath steering
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;

        if (flush) begin
            // Flush beats accept and promotion; a drain this cycle still
            // counts because the consumer already sampled the payload.
            state_next = BUF_EMPTY;
        end else begin
            unique case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next = BUF_FULL;
                        main_load  = 1'b1;
                    end
                end
                BUF_FULL: begin
                    if (accept && drain) begin
                        // Back-to-back: replace main, no bubble.
                        main_load = 1'b1;
                    end else if (accept) begin
                        // Only reachable with a skid entry (otherwise
                        // in_ready implies drain here).
                        state_next = BUF_SKID;
                        skid_load  = 1'b1;
                    end else if (drain) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_SKID: begin
                    if (drain) begin
                        state_next     = BUF_FULL;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = BUF_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        main_data_next = main_data_reg;
        if (main_from_skid) begin
            main_data_next = skid_data;
        end else if (main_load) begin
            main_data_next = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BUF_EMPTY;
            main_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
// Execute-to-Memory pipeline register with valid/ready flow control.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (released synchronously upstream)
//   bus     ex_mem_pipe_reg_if.slave: ValidE/ReadyE/FlushE and the *E
//           payload in, ValidM/ReadyM and the registered *M payload out
// The payload is flattened into one vector and stored by pipe_skid_buf.
// RegWriteM, MemWriteM and MemReadM are qualified with ValidM so that no
// side effect can leak from an empty or flushed slot; the remaining fields
// simply hold their last value.
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit SKID_EN        = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_mem_pipe_reg_if.slave   bus
);

    localparam int PW = ex_mem_width(DATA_WIDTH, REG_ADDR_WIDTH);

    logic [PW-1:0]             in_payload;
    logic [PW-1:0]             out_payload;
    logic                      out_valid;

    logic [DATA_WIDTH-1:0]     alu_result_q;
    logic [DATA_WIDTH-1:0]     write_data_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic [DATA_WIDTH-1:0]     pc_plus4_q;
    logic                      mem_write_q;
    logic                      mem_read_q;
    logic [1:0]                result_src_q;
    logic [2:0]                funct3_q;

    assign in_payload = {bus.ALUResultE, bus.WriteDataE, bus.RdE,
                         bus.RegWriteE, bus.PCPlus4E, bus.MemWriteE,
                         bus.MemReadE, bus.ResultSrcE, bus.funct3E};

    pipe_skid_buf #(
        .PAYLOAD_W (PW),
        .SKID_EN   (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.ValidE),
        .in_ready  (bus.ReadyE),
        .in_data   (in_payload),
        .flush     (bus.FlushE),
        .out_valid (out_valid),
        .out_ready (bus.ReadyM),
        .out_data  (out_payload)
    );

    assign {alu_result_q, write_data_q, rd_q, reg_write_q, pc_plus4_q,
            mem_write_q, mem_read_q, result_src_q, funct3_q} = out_payload;

    assign bus.ValidM     = out_valid;
    assign bus.ALUResultM = alu_result_q;
    assign bus.WriteDataM = write_data_q;
    assign bus.RdM        = rd_q;
    assign bus.PCPlus4M   = pc_plus4_q;
    assign bus.ResultSrcM = result_src_q;
    assign bus.funct3M    = funct3_q;

    // Side-effect controls only assert alongside a valid instruction.
    assign bus.RegWriteM  = reg_write_q & out_valid;
    assign bus.MemWriteM  = mem_write_q & out_valid;
    assign bus.MemReadM   = mem_read_q  & out_valid;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised Execute-to-Memory pipeline register with valid/ready flow control, a 2-entry skid buffer, flush and reset. Sits between the ALU/Execute stage and the data-memory stage. It lets a variable-latency data memory stall Execute without a combinational ready path from Memory back to Execute. Side-effect controls (RegWrite, MemWrite, MemRead) are forced low whenever no valid instruction is presented.

Parameters:
DATA_WIDTH, 32, width of ALUResult, WriteData and PCPlus4
REG_ADDR_WIDTH, 5, destination register index width
SKID_EN, 1, 1 = 2-entry skid buffer with registered ReadyE; 0 = single entry with combinational ReadyE

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ValidE  in  1  Execute presents an instruction
ReadyE  out  1  this block accepts the Execute payload this cycle
FlushE  in  1  discard the incoming payload and every buffered entry
ALUResultE  in  DATA_WIDTH  ALU result
WriteDataE  in  DATA_WIDTH  store data
RdE  in  REG_ADDR_WIDTH  destination register
RegWriteE  in  1  register write enable
PCPlus4E  in  DATA_WIDTH  PC+4
MemWriteE  in  1  store
MemReadE  in  1  load
ResultSrcE  in  2  writeback mux select
funct3E  in  3  access size/sign
ValidM  out  1  Memory-stage payload valid
ReadyM  in  1  Memory stage consumes the payload this cycle
ALUResultM, WriteDataM, RdM, RegWriteM, PCPlus4M, MemWriteM, MemReadM, ResultSrcM, funct3M  out  same widths  registered payload

Behaviour:
- Reset (rst_n=0, asynchronous): both entry valid bits cleared, all M outputs 0, ReadyE=1 once reset is released. rst_n is de-asserted synchronously by the integrator.
- Transfer rules: upstream transfer = ValidE & ReadyE; downstream transfer = ValidM & ReadyM.
- Latency: 1 cycle. A payload accepted at edge N appears on the M outputs after edge N if the main entry is free or drains at that edge.
- Storage: main entry drives the outputs; the skid entry exists only when SKID_EN=1.
- States, SKID_EN=1:
  - EMPTY: ReadyE=1. On accept, go to FULL.
  - FULL: main entry only, ReadyE=1.
    - accept with no drain -> SKID; the new payload goes to the skid entry.
    - accept and drain -> FULL; the new payload goes to main.
    - drain only -> EMPTY.
    - neither -> hold.
  - SKID: ReadyE=0.
    - drain -> FULL; skid moves to main.
    - no drain -> hold.
- ReadyE is a pure register output (~skid_valid) with no path from ReadyM.
- SKID_EN=0: ReadyE = ReadyM | ~ValidM (combinational). States are EMPTY and FULL only.
- Ordering: strict FIFO. No reordering, no duplication, no drop except on flush.
- Stall: while ValidM=1 and ReadyM=0, every M output is stable (bit-identical) until the transfer.
- Side-effect gating: RegWriteM, MemWriteM, MemReadM = stored value & ValidM. Other payload fields are don't-care when ValidM=0 and hold their last value (no enable toggling).
- FlushE=1:
  - The same-cycle input is not stored, even if ValidE & ReadyE.
  - Both valid bits clear at the next edge; ValidM=0 and ReadyE=1 the cycle after.
  - A downstream transfer in the flush cycle still completes, since Memory already sampled it.
  - Flush has priority over accept and over skid-to-main promotion.
- Simultaneous accept and drain in FULL: the old main payload is consumed and the new one loads into main. No bubble; throughput is 1 per cycle.
- Reset mid-stall: entries are lost immediately, ValidM drops to 0 asynchronously.

Decomposition:
- Shared package pipe_pkg:
  - packed struct ex_mem_t holding all payload fields, sized by DATA_WIDTH/REG_ADDR_WIDTH defaults;
  - localparam ResultSrc encodings (ALU=2'b00, MEM=2'b01, PC4=2'b10).
- One sub-module: pipe_skid_buf, a generic 2-entry valid/ready buffer over a parametrised payload width, reusable for the IF/ID and ID/EX registers.
- ex_mem_pipe_reg wraps pipe_skid_buf and adds the side-effect gating.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ValidM=1 -> ValidM, RegWriteM, MemWriteM and MemReadM go 0 immediately; ReadyE=1 after release.
- Streaming: ValidE=1, ReadyM=1 every cycle, ALUResultE=0x10,0x14,0x18 -> ALUResultM shows 0x10,0x14,0x18 on consecutive cycles, 1-cycle lag, no bubbles.
- Stall into skid: main holds 0xA with ReadyM=0, accept 0xB -> ReadyE=0 next cycle, outputs hold 0xA. Then ReadyM=1 for 2 cycles -> 0xA then 0xB, with ReadyE=1 again after the 0xA drain.
- Gating: accept RdE=5, RegWriteE=1, MemWriteE=1, then ValidE=0 -> after the drain, ValidM=0 and RegWriteM=MemWriteM=0 while RdM still reads 5.
- Flush: SKID state holding 0x1,0x2 plus FlushE=1 with ValidE=1 carrying 0x3 -> next cycle ValidM=0, ReadyE=1; 0x1, 0x2 and 0x3 never appear.
- SKID_EN=0: ValidM=1, ReadyM=0 -> ReadyE=0 in the same cycle. Raise ReadyM=1 -> ReadyE=1 combinationally and back-to-back throughput continues.
